wifi_stream_fifo: RTL and testbench
===================================

Name: wifi_stream_fifo

Overview:
- Parametrised stream FIFO for the WiFi PHY bit/symbol pipeline (descrambler, deinterleaver, decoder feeds).
- Successor to the single-bit descrambler FIFO, adding:
  - configurable data width and depth;
  - true full/empty and almost-full/almost-empty flags, plus an occupancy count;
  - sticky overflow/underflow flags and a synchronous flush;
  - a frame-tracking state machine that drives `finished` for the downstream handshake.

Parameters:
- DATA_W, 1, data word width in bits.
- AW, 4, address width; depth = 2^AW words.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear, highest priority.
- we  in  1  write request.
- data_in  in  DATA_W  write data.
- re  in  1  read request.
- data_out  out  DATA_W  registered read data.
- valid_out  out  1  data_out valid, one-cycle pulse per accepted read.
- full  out  1  count == 2^AW.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  AW+1  occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- finished  out  1  high when no frame is in flight.

Behaviour:
- Reset (asynchronous, reset=0):
  - Pointers and count = 0.
  - data_out = 0, valid_out = 0.
  - overflow = 0, underflow = 0.
  - FSM = IDLE, finished = 1.
  - Flags follow count: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Storage:
  - 2^AW x DATA_W register array; no reset required on array contents.
- Write:
  - Accepted iff we && !full && !flush.
  - mem[wr_ptr] <= data_in; wr_ptr increments mod 2^AW (natural wrap).
- Read:
  - Accepted iff re && !empty && !flush.
  - data_out <= mem[rd_ptr] and valid_out <= 1 on the next edge (latency 1 cycle).
  - rd_ptr increments mod 2^AW.
  - valid_out = 0 in any cycle after a non-accepted read.
  - data_out holds its last value when no read is accepted.
- Simultaneous events:
  - Accepted write and accepted read in the same cycle: count unchanged.
  - When empty, a same-cycle write is not readable until the next cycle (no fall-through).
  - When full, the write is rejected even if a read is accepted that cycle.
- Count and flags:
  - count += wr_acc - rd_acc.
  - All flags are combinational from the registered count.
- Error flags:
  - we && full sets overflow; re && empty sets underflow.
  - Both are sticky until flush or reset; the rejected operation has no other effect.
- Flush:
  - Next edge: pointers, count, valid_out, overflow and underflow are cleared, and FSM = IDLE.
  - data_out is held.
  - we and re are ignored in the flush cycle.
- FSM (registered; finished = 1 only in IDLE):
  - IDLE -> FILL on an accepted write.
  - FILL -> DRAIN when we = 0.
  - FILL stays while we = 1.
  - DRAIN -> FILL on we = 1.
  - DRAIN -> IDLE when count == 0 && valid_out == 0.
  - finished therefore falls 1 cycle after the first accepted write.
  - finished rises 1 cycle after the last valid_out pulse, provided the FIFO is empty.
- Rejected writes in IDLE (only possible at AW small / full) do not leave IDLE.
- Threshold constraint: the thresholds must satisfy AEMPTY_TH < AFULL_TH <= 2^AW; this is not checked in RTL.

Test Plan:
- Reset release, no stimulus -> empty=1, full=0, count=0, finished=1, valid_out=0, data_out=0.
- DATA_W=8, AW=4: write 0x01..0x10 (16 words), then read 16 -> full=1 after 16th write; almost_full at count 12; valid_out pulses 16 times with data 0x01..0x10 in order, 1 cycle after each re; empty=1 at end.
- Full, then we=1 with 0xAA and re=0 -> overflow=1, count stays 16, 0xAA never read. Then re with empty -> underflow=1, valid_out stays 0.
- Simultaneous we/re at count=5 for 20 cycles, crossing pointer wrap -> count stays 5, data order preserved, no error flags.
- Frame: 3 writes, gap, 3 reads -> finished 1->0 one cycle after first write; finished ->1 one cycle after 3rd valid_out.
- flush asserted at count=7 with overflow set and we=re=1 -> next cycle count=0, empty=1, overflow=0, finished=1, no write stored. Async reset mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/wifi_stream_fifo_if.sv
// Stream FIFO bus: write handshake, read handshake and status/flag outputs.
interface wifi_stream_fifo_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned AW     = 4
);
  logic              we;
  logic [DATA_W-1:0] data_in;
  logic              re;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;
  logic              finished;

  // Producer/consumer side
  modport master (
    output we, data_in, re,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow, finished
  );

  // FIFO side
  modport slave (
    input  we, data_in, re,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow, finished
  );
endinterface

// File: rtl/wifi_stream_fifo.sv
// Parametrised stream FIFO for the WiFi PHY pipeline with occupancy flags,
// sticky error flags, synchronous flush and a frame-tracking FSM.
module wifi_stream_fifo #(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned AW        = 4,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  wifi_stream_fifo_if.slave  bus
);

  localparam int unsigned DEPTH      = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT  = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_CNT = (AW + 1)'(AEMPTY_TH);
  localparam logic [AW:0] ONE_CNT    = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              finished_q, finished_d;
  state_t            state_q, state_d;

  logic full_c, empty_c, wr_acc, rd_acc;

  // Occupancy flags derived from the registered count
  always_comb begin
    full_c  = (count_q == DEPTH_CNT);
    empty_c = (count_q == '0);
    wr_acc  = bus.we && !full_c && !flush;
    rd_acc  = bus.re && !empty_c && !flush;
  end

  // Datapath next-state: pointers, count, read data and sticky errors
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        data_out_d  = mem[rd_ptr_q];
        valid_out_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
      if (bus.we && full_c) begin
        overflow_d = 1'b1;
      end
      if (bus.re && empty_c) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Frame tracker: finished is high only while no frame is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_acc) state_d = FILL;
      FILL:    if (!bus.we) state_d = DRAIN;
      DRAIN: begin
        if (bus.we) begin
          state_d = FILL;
        end else if (count_q == '0 && !valid_out_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
    finished_d = (state_d == IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      finished_q  <= 1'b1;
      state_q     <= IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      finished_q  <= finished_d;
      state_q     <= state_d;
    end
  end

  // Storage array, written on accepted writes only
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= AFULL_CNT);
  assign bus.almost_empty = (count_q <= AEMPTY_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.finished     = finished_q;

endmodule

// File: tb/tb_wifi_stream_fifo.sv
// Directed table-driven bench for wifi_stream_fifo (DATA_W=8, AW=4).
module tb_wifi_stream_fifo;

  logic clk;
  logic rst_n;
  logic flush;

  wifi_stream_fifo_if #(.DATA_W(8), .AW(4)) bus ();

  wifi_stream_fifo #(
    .DATA_W   (8),
    .AW       (4),
    .AFULL_TH (12),
    .AEMPTY_TH(2)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       we;
    logic       re;
    logic [7:0] din;
    int         cnt;
    logic       vld;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
    logic       fin;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic we, input logic re, input int din,
                     input int cnt, input logic vld, input int dout,
                     input logic ovf, input logic unf, input logic fin);
    vec_t v;
    v.fl = fl; v.we = we; v.re = re; v.din = din[7:0];
    v.cnt = cnt; v.vld = vld; v.dout = dout[7:0];
    v.ovf = ovf; v.unf = unf; v.fin = fin;
    vecs.push_back(v);
  endtask

  // Compare every output against expected count, flags derived from the count
  task automatic check_all(input string tag, input int cnt, input logic vld, input int dout,
                           input logic ovf, input logic unf, input logic fin);
    chk({tag, " count"},        int'(bus.count),        cnt);
    chk({tag, " valid_out"},    int'(bus.valid_out),    int'(vld));
    chk({tag, " data_out"},     int'(bus.data_out),     dout);
    chk({tag, " full"},         int'(bus.full),         (cnt == 16) ? 1 : 0);
    chk({tag, " empty"},        int'(bus.empty),        (cnt == 0) ? 1 : 0);
    chk({tag, " almost_full"},  int'(bus.almost_full),  (cnt >= 12) ? 1 : 0);
    chk({tag, " almost_empty"}, int'(bus.almost_empty), (cnt <= 2) ? 1 : 0);
    chk({tag, " overflow"},     int'(bus.overflow),     int'(ovf));
    chk({tag, " underflow"},    int'(bus.underflow),    int'(unf));
    chk({tag, " finished"},     int'(bus.finished),     int'(fin));
  endtask

  initial begin
    // Fill 16 words 0x01..0x10, overflow attempt, drain 16, underflow, flush
    for (int k = 1; k <= 16; k++) add(0, 1, 0, k, k, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'hAA, 16, 0, 8'h00, 1, 0, 0);
    for (int j = 1; j <= 16; j++) add(0, 0, 1, 0, 16 - j, 1, j, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 8'h10, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 8'h10, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 8'h10, 0, 0, 1);
    // Count held at 5 with simultaneous read/write across the pointer wrap
    for (int k = 0; k < 5; k++) add(0, 1, 0, 8'h20 + k, k + 1, 0, 8'h10, 0, 0, 0);
    for (int j = 0; j < 20; j++) add(0, 1, 1, 8'h25 + j, 5, 1, 8'h20 + j, 0, 0, 0);
    for (int m = 0; m < 5; m++) add(0, 0, 1, 0, 4 - m, 1, 8'h34 + m, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h38, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h38, 0, 0, 1);
    // Frame: 3 writes, gap, 3 reads, finished timing
    for (int k = 0; k < 3; k++) add(0, 1, 0, 8'h51 + k, k + 1, 0, 8'h38, 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 8'h38, 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 8'h38, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 2 - k, 1, 8'h51 + k, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h53, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h53, 0, 0, 1);
    // Flush at count 7 with overflow set and we=re=1
    for (int k = 1; k <= 16; k++) add(0, 1, 0, 8'h60 + k, k, 0, 8'h53, 0, 0, 0);
    add(0, 1, 0, 8'hAA, 16, 0, 8'h53, 1, 0, 0);
    for (int j = 1; j <= 9; j++) add(0, 0, 1, 0, 16 - j, 1, 8'h60 + j, 1, 0, 0);
    add(1, 1, 1, 8'hEE, 0, 0, 8'h69, 0, 0, 1);
    add(0, 1, 0, 8'h77, 1, 0, 8'h69, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 8'h77, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h77, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h77, 0, 0, 1);

    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.data_in = '0;

    // Reset release with no stimulus
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset", 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      flush       = vecs[i].fl;
      bus.we      = vecs[i].we;
      bus.re      = vecs[i].re;
      bus.data_in = vecs[i].din;
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].dout,
                vecs[i].ovf, vecs[i].unf, vecs[i].fin);
    end

    // Asynchronous reset in the middle of a frame, with a read pulse live
    @(negedge clk);
    flush = 1'b0; bus.re = 1'b0; bus.we = 1'b1; bus.data_in = 8'h91;
    @(negedge clk);
    bus.data_in = 8'h92;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b1;
    @(posedge clk); #1;
    check_all("pre_rst", 1, 1, 8'h91, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    bus.re = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
